id_ex_pipe_stage: RTL and testbench
===================================

Name: id_ex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage register with a valid/ready handshake and a 2-entry skid buffer, so upstream ready is a registered signal.
- Carries decoded control bits (EX/M/WB groups) and the data payload: PC, operands, register addresses, immediate and ALU-control field.
- Supports stall by backpressure, flush (bubble insertion) and control-only squash.
- Sits between the decode and execute stages of the pipelined RISC-V core.

Parameters:
- XLEN, 32, width of PC, operand, immediate and ALU-control fields
- REG_AW, 5, register address width
- CTRL_W, 9, packed control vector width ({ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemToReg, spare})

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  upstream (ID) presents a valid instruction
- o_ready  out  1  stage can accept; registered
- i_ctrl  in  CTRL_W  control vector from ID
- i_pc  in  XLEN  instruction PC
- i_rs1_data, i_rs2_data  in  XLEN  register file read data
- i_rs1, i_rs2, i_rd  in  REG_AW  register addresses
- i_imm  in  XLEN  immediate
- i_alu_ctl  in  XLEN  ALU-control source field (funct bits)
- i_flush  in  1  kill all held and incoming instructions
- i_squash  in  1  accept the incoming instruction with its control vector forced to 0 (load-use bubble)
- o_valid  out  1  EX-side instruction valid
- i_ready  in  1  EX consumes the instruction this cycle
- o_ctrl, o_pc, o_rs1_data, o_rs2_data, o_rs1, o_rs2, o_rd, o_imm, o_alu_ctl  out  (as inputs)  registered payload to EX

Behaviour:
- Reset (async, i_reset_n=0): all outputs 0, o_valid=0, skid empty, o_ready=1 on the first cycle after release.
- Storage: main register (drives outputs directly) plus skid register; each has its own valid bit.
- accept = i_valid & o_ready; take = o_valid & i_ready.
- Latency 1 cycle: an instruction accepted at edge N is on the outputs after edge N when main is empty or taken.
- Per-edge update, evaluated in this priority order:
  1. i_flush=1: both valid bits cleared, o_ctrl and the skid ctrl zeroed, incoming instruction dropped. Data fields may hold stale values.
  2. take and skid valid: skid moves to main. If accept also occurs, the new instruction goes to skid (skid valid stays 1).
  3. take or main empty: an accepted instruction loads main. With no accept, main valid becomes 0 and o_ctrl is zeroed.
  4. Main valid and not taken: an accepted instruction loads skid.
- o_ready next = !(skid valid next). It is never combinationally dependent on i_ready.
- Skid-full case: with o_ready=0, i_valid is ignored. Upstream must hold its data.
- i_squash with accept: the entry is written with ctrl=0 and valid=1, other fields captured normally. Squash without accept has no effect.
- o_ctrl is always 0 whenever o_valid=0, so downstream may ignore o_valid for side-effect gating.
- All payload fields are captured from their own inputs. No field holds its previous value while loading.
- Outputs are stable while o_valid=1 and i_ready=0.
- Reset asserted mid-transfer: everything is discarded immediately and there is no partial update.

Optional Feature:
- Macro PIPE_STAGE_PERF_CNT_EN.
- When defined: adds outputs o_stall_cnt (32) and o_bubble_cnt (32), both reset to 0.
  - stall_cnt increments each cycle o_valid & !i_ready.
  - bubble_cnt increments each cycle with accept & i_squash, or with i_flush while any entry is valid.
  - Both counters saturate at all-ones.
- When undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef ctrl_t (packed struct of the CTRL_W fields)
  - typedef id_ex_payload_t (packed payload struct)
  - localparams for ALUOp encodings
  - constant CTRL_NOP='0
- One sub-module, pipe_skid_buf: generic 2-entry valid/ready skid buffer over a packed payload, with flush and clear-ctrl inputs. The top instantiates it and applies squash.

Test Plan:
- Reset and pass-through:
  - Drive i_reset_n=0 mid-stream with all inputs nonzero -> all outputs 0, o_valid=0.
  - Release reset, then stream pc=0x100,0x104,0x108 with i_ready=1 -> the same values appear one cycle later, in order, o_ready=1 throughout.
- Backpressure:
  - i_ready=0 for 3 cycles while upstream offers pc=0x200,0x204,0x208 -> 0x200 held on outputs, 0x204 in skid, o_ready=0, 0x208 held by upstream.
  - Raise i_ready -> outputs 0x200, 0x204, 0x208 on consecutive cycles, none lost or duplicated.
- Flush:
  - Main and skid both valid plus i_valid=1 with i_flush=1 -> next cycle o_valid=0, o_ctrl=0, o_ready=1.
  - The next accepted pc=0x300 appears normally.
- Squash:
  - Accept pc=0x400 with ctrl=9'h1FF and i_squash=1 -> o_valid=1, o_pc=0x400, o_ctrl=0, rd/imm captured.
- ALU-control capture:
  - Load i_alu_ctl=0x40000005, then 0x00000000 -> o_alu_ctl follows 0x40000005, then 0x00000000.
- Perf counters (macro on):
  - 5 stalled cycles and 2 squashes -> o_stall_cnt=5, o_bubble_cnt=2.
  - Build with the macro undefined compiles without those ports.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the decode/execute pipeline register.
// Holds the control-vector layout, the ID/EX payload layout and ALUOp encodings.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W_DEF = 9;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       spare;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Control sits in the least significant bits so a single mask can clear it.
  typedef struct packed {
    logic [XLEN_DEF-1:0]   alu_ctl;
    logic [XLEN_DEF-1:0]   imm;
    logic [REG_AW_DEF-1:0] rd;
    logic [REG_AW_DEF-1:0] rs2;
    logic [REG_AW_DEF-1:0] rs1;
    logic [XLEN_DEF-1:0]   rs2_data;
    logic [XLEN_DEF-1:0]   rs1_data;
    logic [XLEN_DEF-1:0]   pc;
    ctrl_t                 ctrl;
  } id_ex_payload_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; 1-cycle latency, up_rdy is registered
// (drops only when the skid entry fills). Control occupies the low CW bits of the payload.
module pipe_skid_buf #(
  parameter int PW = 8,
  parameter int CW = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_flush,
  input  logic          i_clr_ctrl,
  input  logic          up_vld,
  output logic          up_rdy,
  input  logic [PW-1:0] up_dat,
  output logic          dn_vld,
  input  logic          dn_rdy,
  output logic [PW-1:0] dn_dat
);

  localparam logic [PW-1:0] CTRL_MASK = {{(PW-CW){1'b0}}, {CW{1'b1}}};

  logic          main_vld, skid_vld;
  logic [PW-1:0] main_dat, skid_dat;
  logic          main_vld_nxt, skid_vld_nxt;
  logic [PW-1:0] main_dat_nxt, skid_dat_nxt;
  logic [PW-1:0] in_dat;
  logic          accept, take;

  assign accept = up_vld & up_rdy;
  assign take   = main_vld & dn_rdy;
  assign in_dat = i_clr_ctrl ? (up_dat & ~CTRL_MASK) : up_dat;

  always_comb begin
    main_vld_nxt = main_vld;
    skid_vld_nxt = skid_vld;
    main_dat_nxt = main_dat;
    skid_dat_nxt = skid_dat;
    if (i_flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
      main_dat_nxt = main_dat & ~CTRL_MASK;
      skid_dat_nxt = skid_dat & ~CTRL_MASK;
    end else if (take && skid_vld) begin
      main_vld_nxt = 1'b1;
      main_dat_nxt = skid_dat;
      if (accept) begin
        skid_dat_nxt = in_dat;
      end else begin
        skid_vld_nxt = 1'b0;
        skid_dat_nxt = skid_dat & ~CTRL_MASK;
      end
    end else if (take || !main_vld) begin
      if (accept) begin
        main_vld_nxt = 1'b1;
        main_dat_nxt = in_dat;
      end else begin
        // Draining leaves a bubble whose control must read as a no-op.
        main_vld_nxt = 1'b0;
        main_dat_nxt = main_dat & ~CTRL_MASK;
      end
    end else if (accept) begin
      skid_vld_nxt = 1'b1;
      skid_dat_nxt = in_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
      up_rdy   <= 1'b1;
    end else begin
      main_vld <= main_vld_nxt;
      skid_vld <= skid_vld_nxt;
      main_dat <= main_dat_nxt;
      skid_dat <= skid_dat_nxt;
      up_rdy   <= !skid_vld_nxt;
    end
  end

  assign dn_vld = main_vld;
  assign dn_dat = main_dat;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register: 1-cycle latency, registered o_ready via a 2-entry skid buffer,
// flush and squash support. Define PIPE_STAGE_PERF_CNT_EN for stall/bubble counters.
module id_ex_pipe_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 9
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [XLEN-1:0]   i_alu_ctl,
  input  logic              i_flush,
  input  logic              i_squash,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [REG_AW-1:0] o_rs1,
  output logic [REG_AW-1:0] o_rs2,
  output logic [REG_AW-1:0] o_rd,
  output logic [XLEN-1:0]   o_imm,
  output logic [XLEN-1:0]   o_alu_ctl
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_bubble_cnt
`endif
);

  localparam int PW = 5 * XLEN + 3 * REG_AW + CTRL_W;

  logic [PW-1:0] up_dat, dn_dat;

  assign up_dat = {i_alu_ctl, i_imm, i_rd, i_rs2, i_rs1,
                   i_rs2_data, i_rs1_data, i_pc, i_ctrl};

  // Squash is applied inside the buffer so it hits whichever entry the instruction lands in.
  pipe_skid_buf #(
    .PW (PW),
    .CW (CTRL_W)
  ) u_skid (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_flush    (i_flush),
    .i_clr_ctrl (i_squash),
    .up_vld     (i_valid),
    .up_rdy     (o_ready),
    .up_dat     (up_dat),
    .dn_vld     (o_valid),
    .dn_rdy     (i_ready),
    .dn_dat     (dn_dat)
  );

  assign {o_alu_ctl, o_imm, o_rd, o_rs2, o_rs1,
          o_rs2_data, o_rs1_data, o_pc, o_ctrl} = dn_dat;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic accept, any_vld;

  assign accept  = i_valid & o_ready;
  // The skid entry is occupied exactly when o_ready is low.
  assign any_vld = o_valid | !o_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (o_valid && !i_ready)
        o_stall_cnt <= sat_inc32(o_stall_cnt);
      if ((accept && i_squash) || (i_flush && any_vld))
        o_bubble_cnt <= sat_inc32(o_bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed vector table, hand sequences and random traffic
// against a capacity-2 FIFO reference model.
module tb_id_ex_pipe_stage;
  import pipe_pkg::*;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] alu_ctl;
  } pl_t;

  typedef struct {
    logic        v, r, fl, sq;
    logic [31:0] pc;
    logic [8:0]  ctrl;
    logic        ev, erdy;
    logic [31:0] epc;
    logic [8:0]  ectrl;
  } vec_t;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_reset_n, i_valid, i_ready, i_flush, i_squash;
  logic o_ready, o_valid;
  pl_t  in_p, out_p;
  logic [8:0]  i_ctrl, o_ctrl;
  logic [31:0] i_pc, i_rs1_data, i_rs2_data, i_imm, i_alu_ctl;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm, o_alu_ctl;
  logic [4:0]  i_rs1, i_rs2, i_rd, o_rs1, o_rs2, o_rd;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] o_stall_cnt, o_bubble_cnt;
`endif

  assign i_ctrl     = in_p.ctrl;
  assign i_pc       = in_p.pc;
  assign i_rs1_data = in_p.rs1_data;
  assign i_rs2_data = in_p.rs2_data;
  assign i_rs1      = in_p.rs1;
  assign i_rs2      = in_p.rs2;
  assign i_rd       = in_p.rd;
  assign i_imm      = in_p.imm;
  assign i_alu_ctl  = in_p.alu_ctl;
  assign out_p = {o_ctrl, o_pc, o_rs1_data, o_rs2_data, o_rs1, o_rs2, o_rd, o_imm, o_alu_ctl};

  id_ex_pipe_stage dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_ctrl(i_ctrl), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_imm(i_imm), .i_alu_ctl(i_alu_ctl),
    .i_flush(i_flush), .i_squash(i_squash), .o_valid(o_valid), .i_ready(i_ready),
    .o_ctrl(o_ctrl), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm), .o_alu_ctl(o_alu_ctl)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .o_stall_cnt(o_stall_cnt), .o_bubble_cnt(o_bubble_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the stage is a FIFO of capacity two; ready reflects room after the edge.
  pl_t  q[$];
  logic m_rdy;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] pc, input logic [8:0] c);
    pl_t p;
    p.ctrl     = c;
    p.pc       = pc;
    p.rs1_data = pc + 32'h1111;
    p.rs2_data = ~pc;
    p.rs1      = pc[6:2];
    p.rs2      = pc[6:2] ^ 5'h1f;
    p.rd       = pc[6:2] + 5'd3;
    p.imm      = pc << 4;
    p.alu_ctl  = {pc[15:0], 16'h0033};
    return p;
  endfunction

  task automatic drive(input logic v, input logic r, input logic fl, input logic sq, input pl_t p);
    i_valid  = v;
    i_ready  = r;
    i_flush  = fl;
    i_squash = sq;
    in_p     = p;
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b1;
  endtask

  task automatic step();
    logic acc;
    pl_t  e;
    @(posedge i_clk);
    acc = i_valid & m_rdy;
    if (i_flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && i_ready) void'(q.pop_front());
      if (acc) begin
        e = in_p;
        if (i_squash) e.ctrl = '0;
        q.push_back(e);
      end
    end
    m_rdy = (q.size() < 2);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 192'(o_valid), 192'(q.size() > 0));
    chk({tag, ".ready"}, 192'(o_ready), 192'(m_rdy));
    if (q.size() > 0) chk({tag, ".payload"}, 192'(out_p), 192'(q[0]));
    else              chk({tag, ".idle_ctrl"}, 192'(o_ctrl), 192'(CTRL_NOP));
  endtask

  function automatic vec_t row(input logic v, r, fl, sq, input logic [31:0] pc, input logic [8:0] c,
                               input logic ev, erdy, input logic [31:0] epc, input logic [8:0] ec);
    vec_t x;
    x.v = v; x.r = r; x.fl = fl; x.sq = sq; x.pc = pc; x.ctrl = c;
    x.ev = ev; x.erdy = erdy; x.epc = epc; x.ectrl = ec;
    return x;
  endfunction

  vec_t tbl[18];
  pl_t  p;

  initial begin
    // pass-through
    tbl[0]  = row(1,1,0,0, 32'h100, 9'h0A0, 1,1, 32'h100, 9'h0A0);
    tbl[1]  = row(1,1,0,0, 32'h104, 9'h0A1, 1,1, 32'h104, 9'h0A1);
    tbl[2]  = row(1,1,0,0, 32'h108, 9'h0A2, 1,1, 32'h108, 9'h0A2);
    tbl[3]  = row(0,1,0,0, 32'h10C, 9'h0A3, 0,1, 32'h0,   9'h000);
    // backpressure: 0x208 must wait upstream until ready returns
    tbl[4]  = row(1,0,0,0, 32'h200, 9'h0B0, 1,1, 32'h200, 9'h0B0);
    tbl[5]  = row(1,0,0,0, 32'h204, 9'h0B1, 1,0, 32'h200, 9'h0B0);
    tbl[6]  = row(1,0,0,0, 32'h208, 9'h0B2, 1,0, 32'h200, 9'h0B0);
    tbl[7]  = row(1,1,0,0, 32'h208, 9'h0B2, 1,1, 32'h204, 9'h0B1);
    tbl[8]  = row(1,1,0,0, 32'h208, 9'h0B2, 1,1, 32'h208, 9'h0B2);
    tbl[9]  = row(0,1,0,0, 32'h20C, 9'h0B3, 0,1, 32'h0,   9'h000);
    // flush with both entries full and a new instruction offered
    tbl[10] = row(1,0,0,0, 32'h2F0, 9'h0C0, 1,1, 32'h2F0, 9'h0C0);
    tbl[11] = row(1,0,0,0, 32'h2F4, 9'h0C1, 1,0, 32'h2F0, 9'h0C0);
    tbl[12] = row(1,0,1,0, 32'h2F8, 9'h0C2, 0,1, 32'h0,   9'h000);
    tbl[13] = row(1,1,0,0, 32'h300, 9'h0C3, 1,1, 32'h300, 9'h0C3);
    tbl[14] = row(0,1,0,0, 32'h304, 9'h0C4, 0,1, 32'h0,   9'h000);
    // squash: with accept clears ctrl only, without accept does nothing
    tbl[15] = row(1,1,0,1, 32'h400, 9'h1FF, 1,1, 32'h400, 9'h000);
    tbl[16] = row(0,1,0,1, 32'h404, 9'h1FF, 0,1, 32'h0,   9'h000);
    tbl[17] = row(0,1,1,0, 32'h408, 9'h1FF, 0,1, 32'h0,   9'h000);

    i_reset_n = 1'b0;
    drive(1, 1, 0, 1, mk(32'hDEADBEE0, 9'h1FF));
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset.outputs", 192'(out_p), 192'(0));
    chk("reset.valid", 192'(o_valid), 192'(0));
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("reset.counters", 192'({o_stall_cnt, o_bubble_cnt}), 192'(0));
`endif
    drive(0, 1, 0, 0, mk(32'h0, 9'h0));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    #1;
    chk("release.ready", 192'(o_ready), 192'(1));

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].fl, tbl[i].sq, mk(tbl[i].pc, tbl[i].ctrl));
      step();
      chk($sformatf("vec%0d.valid", i), 192'(o_valid), 192'(tbl[i].ev));
      chk($sformatf("vec%0d.ready", i), 192'(o_ready), 192'(tbl[i].erdy));
      chk($sformatf("vec%0d.ctrl", i), 192'(o_ctrl), 192'(tbl[i].ectrl));
      if (tbl[i].ev)
        chk($sformatf("vec%0d.payload", i), 192'(out_p), 192'(mk(tbl[i].epc, tbl[i].ectrl)));
    end

    // ALU-control capture, including loading all zeros after a nonzero value
    p = mk(32'h500, 9'h021);
    p.alu_ctl = 32'h40000005;
    drive(1, 1, 0, 0, p);
    step();
    chk("alu_ctl.first", 192'(o_alu_ctl), 192'(32'h40000005));
    p = mk(32'h504, 9'h022);
    p.alu_ctl = 32'h0;
    drive(1, 1, 0, 0, p);
    step();
    chk("alu_ctl.second", 192'(o_alu_ctl), 192'(32'h0));
    chk("alu_ctl.pc", 192'(o_pc), 192'(32'h504));
    drive(0, 1, 0, 0, p);
    step();
    check_model("drain");

    for (int n = 0; n < 600; n++) begin
      p.ctrl     = 9'($urandom);
      p.pc       = $urandom;
      p.rs1_data = $urandom;
      p.rs2_data = $urandom;
      p.rs1      = 5'($urandom);
      p.rs2      = 5'($urandom);
      p.rd       = 5'($urandom);
      p.imm      = $urandom;
      p.alu_ctl  = $urandom;
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), p);
      step();
      check_model($sformatf("rnd%0d", n));
    end

    // asynchronous reset in the middle of a transfer
    drive(1, 0, 0, 0, mk(32'h7777_0000, 9'h155));
    step();
    drive(1, 0, 0, 0, mk(32'h7777_0004, 9'h0AA));
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    chk("midreset.outputs", 192'(out_p), 192'(0));
    chk("midreset.valid", 192'(o_valid), 192'(0));
    @(negedge i_clk);
    i_reset_n = 1'b1;
    drive(0, 1, 0, 0, mk(32'h0, 9'h0));
    step();
    check_model("postreset");

`ifdef PIPE_STAGE_PERF_CNT_EN
    drive(1, 0, 0, 1, mk(32'h600, 9'h1FF));
    step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 0, mk(32'h604, 9'h001));
      step();
    end
    drive(0, 1, 0, 0, mk(32'h604, 9'h001));
    step();
    drive(1, 1, 0, 1, mk(32'h608, 9'h1FF));
    step();
    drive(0, 1, 0, 0, mk(32'h60C, 9'h001));
    step();
    chk("perf.stall", 192'(o_stall_cnt), 192'(5));
    chk("perf.bubble", 192'(o_bubble_cnt), 192'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
